// File: rtl/l2_noc_trace_pkg.sv
// l2_noc_trace_pkg: NoC header field positions, channel ids and trace entry layout.
// Also provides `L2_DBG_MODULE, the name parents use to instantiate the tracer.
`ifndef L2_DBG_MODULE
`define L2_DBG_MODULE l2_noc_trace
`endif
package l2_noc_trace_pkg;
    localparam int NOC_DATA_WIDTH   = 64;
    localparam int MSG_LENGTH       = 29;
    localparam int MSG_LENGTH_WIDTH = 8;
    localparam int TS_W             = 16;
    localparam int TRACE_W          = 2 + NOC_DATA_WIDTH + TS_W;
    localparam logic [1:0] CHAN_NOC1 = 2'd1;
    localparam logic [1:0] CHAN_NOC2 = 2'd2;
    localparam logic [1:0] CHAN_NOC3 = 2'd3;

    typedef enum logic {HDR, BODY} chan_state_e;

    function automatic logic [MSG_LENGTH_WIDTH-1:0] msg_len(input logic [NOC_DATA_WIDTH-1:0] flit);
        return flit[MSG_LENGTH -: MSG_LENGTH_WIDTH];
    endfunction
endpackage

// File: rtl/l2_noc_trace_fifo.sv
// l2_noc_trace_fifo: power-of-two FIFO; pointers carry an extra wrap bit for full/empty.
module l2_noc_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wp_q, rp_q;

    assign empty_o = wp_q == rp_q;
    assign full_o  = wp_q[AW] != rp_q[AW] && wp_q[AW-1:0] == rp_q[AW-1:0];
    assign rdata_o = mem_q[rp_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wp_q[AW-1:0]] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_q + (AW+1)'(push_i);
            rp_q <= rp_q + (AW+1)'(pop_i);
        end
    end
endmodule

// File: rtl/l2_noc_trace.sv
// l2_noc_trace: passive header tracer on the L2 NOC1/2/3 ports with per-channel counters.
// Define L2_NOC_TRACE_TIMESTAMP_EN to stamp entries with a free-running 16-bit cycle count.
module l2_noc_trace
    import l2_noc_trace_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      noc1_valid_in,
    input  logic [NOC_DATA_WIDTH-1:0] noc1_data_in,
    input  logic                      noc1_ready_in,
    input  logic                      noc2_valid_out,
    input  logic [NOC_DATA_WIDTH-1:0] noc2_data_out,
    input  logic                      noc2_ready_out,
    input  logic                      noc3_valid_in,
    input  logic [NOC_DATA_WIDTH-1:0] noc3_data_in,
    input  logic                      noc3_ready_in,
    output logic                      trace_valid,
    output logic [TRACE_W-1:0]        trace_data,
    input  logic                      trace_ready,
    output logic [CNT_W-1:0]          msg_cnt1,
    output logic [CNT_W-1:0]          msg_cnt2,
    output logic [CNT_W-1:0]          msg_cnt3,
    output logic [CNT_W-1:0]          drop_cnt
);
    logic [2:0]                acc, hdr;
    logic [NOC_DATA_WIDTH-1:0] flit [3];
    logic [TS_W-1:0]           ts;
    logic [1:0]                win_id, n_hdr, n_drop;
    logic [NOC_DATA_WIDTH-1:0] win_flit;
    logic                      cap_valid_q, full, empty, pop, push, full_drop;
    logic [TRACE_W-1:0]        cap_q;
    logic [CNT_W-1:0]          drop_q, drop_d;
    logic [CNT_W:0]            drop_sum;

    assign acc     = {noc3_valid_in & noc3_ready_in, noc2_valid_out & noc2_ready_out, noc1_valid_in & noc1_ready_in};
    assign flit[0] = noc1_data_in;
    assign flit[1] = noc2_data_out;
    assign flit[2] = noc3_data_in;

    for (genvar g = 0; g < 3; g++) begin : g_chan
        chan_state_e                 state_q;
        logic [MSG_LENGTH_WIDTH-1:0] rem_q;
        logic [CNT_W-1:0]            msg_q;
        assign hdr[g] = acc[g] && state_q == HDR;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= HDR;
                rem_q   <= '0;
                msg_q   <= '0;
            end else if (acc[g]) begin
                if (state_q == HDR) begin
                    rem_q   <= msg_len(flit[g]);
                    state_q <= msg_len(flit[g]) == 0 ? HDR : BODY;
                    msg_q   <= &msg_q ? msg_q : msg_q + CNT_W'(1);
                end else begin
                    rem_q   <= rem_q - MSG_LENGTH_WIDTH'(1);
                    state_q <= rem_q == 1 ? HDR : BODY;
                end
            end
        end
    end

    assign msg_cnt1 = g_chan[0].msg_q;
    assign msg_cnt2 = g_chan[1].msg_q;
    assign msg_cnt3 = g_chan[2].msg_q;

`ifdef L2_NOC_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_q + TS_W'(1);
    end
    assign ts = ts_q;
`else
    assign ts = '0;
`endif

    // Fixed priority noc1 > noc3 > noc2; every other simultaneous header is a drop.
    assign win_id    = hdr[0] ? CHAN_NOC1 : hdr[2] ? CHAN_NOC3 : CHAN_NOC2;
    assign win_flit  = hdr[0] ? flit[0] : hdr[2] ? flit[2] : flit[1];
    assign n_hdr     = 2'(hdr[0]) + 2'(hdr[1]) + 2'(hdr[2]);
    assign pop       = trace_valid && trace_ready;
    assign push      = cap_valid_q && (!full || pop);
    assign full_drop = cap_valid_q && full && !pop;
    assign n_drop    = (|hdr ? n_hdr - 2'd1 : 2'd0) + 2'(full_drop);
    assign drop_sum  = {1'b0, drop_q} + (CNT_W+1)'(n_drop);
    assign drop_d    = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    assign drop_cnt  = drop_q;
    assign trace_valid = !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid_q <= 1'b0;
            cap_q       <= '0;
            drop_q      <= '0;
        end else begin
            cap_valid_q <= |hdr;
            if (|hdr) cap_q <= {win_id, win_flit, ts};
            drop_q <= drop_d;
        end
    end

    l2_noc_trace_fifo #(.WIDTH(TRACE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (push),
        .wdata_i(cap_q),
        .pop_i  (pop),
        .rdata_o(trace_data),
        .full_o (full),
        .empty_o(empty)
    );
endmodule

// File: tb/tb_l2_noc_trace.sv
// tb_l2_noc_trace: scoreboard bench; a message-level model queues expected trace entries.
// Define L2_NOC_TRACE_TIMESTAMP_EN in both builds to check non-zero timestamps.
module tb_l2_noc_trace;
    import l2_noc_trace_pkg::*;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef L2_NOC_TRACE_TIMESTAMP_EN
    localparam int TS_DELTA = 5;
`else
    localparam int TS_DELTA = 0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic [2:0] val = '0, rdy = '0;
    logic [NOC_DATA_WIDTH-1:0] dat [3];
    logic tr_rdy = 1'b0;
    logic trace_valid;
    logic [TRACE_W-1:0] trace_data;
    logic [CNT_W-1:0] msg_cnt1, msg_cnt2, msg_cnt3, drop_cnt;

    int checks = 0, errors = 0;
    int rem_m [3];
    int msg_m [3];
    int drop_m, occ, ts_m, pops = 0;
    bit stg_v;
    logic [TRACE_W-1:0] stg;
    logic [TRACE_W-1:0] exp_q [$];
    logic [15:0] got_ts [$];

    always #5 clk = ~clk;

    l2_noc_trace #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .noc1_valid_in(val[0]), .noc1_data_in(dat[0]), .noc1_ready_in(rdy[0]),
        .noc2_valid_out(val[1]), .noc2_data_out(dat[1]), .noc2_ready_out(rdy[1]),
        .noc3_valid_in(val[2]), .noc3_data_in(dat[2]), .noc3_ready_in(rdy[2]),
        .trace_valid(trace_valid), .trace_data(trace_data), .trace_ready(tr_rdy),
        .msg_cnt1(msg_cnt1), .msg_cnt2(msg_cnt2), .msg_cnt3(msg_cnt3), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int x);
        return x > CMAX ? CMAX : x;
    endfunction

    function automatic logic [15:0] ts_exp();
`ifdef L2_NOC_TRACE_TIMESTAMP_EN
        return 16'(ts_m);
`else
        return 16'h0;
`endif
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; val = '0; rdy = '0; tr_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin rem_m[c] = 0; msg_m[c] = 0; end
        drop_m = 0; occ = 0; ts_m = 0; stg_v = 0;
        exp_q.delete();
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
    endtask

    task automatic drive(input int c, input int len);
        val = '0; rdy = '0;
        val[c] = 1'b1; rdy[c] = 1'b1;
        dat[c] = {$urandom, $urandom};
        dat[c][29:22] = 8'(len);
    endtask

    task automatic idle();
        val = '0; rdy = '0;
    endtask

    // Predict what the coming clock edge does at message level, then advance one cycle.
    task automatic step();
        bit h [3];
        bit pop;
        int n, w;
        n = 0;
        for (int c = 0; c < 3; c++) begin
            h[c] = 0;
            if (val[c] && rdy[c]) begin
                if (rem_m[c] == 0) begin
                    h[c] = 1; n++;
                    rem_m[c] = int'(dat[c][29:22]);
                    msg_m[c] = sat(msg_m[c] + 1);
                end else rem_m[c]--;
            end
        end
        pop = occ > 0 && tr_rdy;
        if (stg_v) begin
            if (occ < DEPTH || pop) begin exp_q.push_back(stg); occ++; end
            else drop_m = sat(drop_m + 1);
        end
        if (pop) occ--;
        stg_v = n > 0;
        if (n > 0) begin
            drop_m = sat(drop_m + n - 1);
            w = h[0] ? 0 : h[2] ? 2 : 1;
            stg = {2'(w + 1), dat[w], ts_exp()};
        end
        ts_m = (ts_m + 1) % 65536;
        @(posedge clk); #1;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_msg1"}, msg_cnt1, msg_m[0]);
        chk({tag, "_msg2"}, msg_cnt2, msg_m[1]);
        chk({tag, "_msg3"}, msg_cnt3, msg_m[2]);
        chk({tag, "_drop"}, drop_cnt, drop_m);
    endtask

    // Monitor: pops the scoreboard on every DUT handshake and checks hold-while-stalled.
    initial begin
        logic [TRACE_W-1:0] held;
        bit hold;
        hold = 0;
        forever begin
            @(negedge clk);
            if (hold && trace_valid) chk("hold", trace_data, held);
            hold = trace_valid && !tr_rdy;
            held = trace_data;
            if (trace_valid && tr_rdy) begin
                pops++;
                got_ts.push_back(trace_data[15:0]);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL entry: got %0h expected no entry", trace_data);
                end else chk("entry", trace_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        int p0;
        for (int c = 0; c < 3; c++) dat[c] = '0;
        do_reset();
        chk("rst_valid", trace_valid, 0);
        chk("rst_msg1", msg_cnt1, 0);
        chk("rst_msg2", msg_cnt2, 0);
        chk("rst_msg3", msg_cnt3, 0);
        chk("rst_drop", drop_cnt, 0);

        // header of length 2, two payload flits
        tr_rdy = 1'b1; p0 = pops;
        drive(0, 2); step();
        drive(0, 7); step();
        drive(0, 7); step();
        idle(); repeat (3) step();
        chk("len2_msg1", msg_cnt1, 1);
        chk("len2_pops", pops - p0, 1);
        chk("len2_drop", drop_cnt, 0);
        chk("len2_valid", trace_valid, 0);

        // three simultaneous headers
        p0 = pops;
        drive(0, 0); val = 3'b111; rdy = 3'b111;
        dat[1] = {$urandom, $urandom}; dat[1][29:22] = 8'd0;
        dat[2] = {$urandom, $urandom}; dat[2][29:22] = 8'd0;
        step();
        idle(); repeat (3) step();
        chk("tri_drop", drop_cnt, 2);
        chk("tri_msg1", msg_cnt1, 2);
        chk("tri_msg2", msg_cnt2, 1);
        chk("tri_msg3", msg_cnt3, 1);
        chk("tri_pops", pops - p0, 1);

        // overflow by one, then push+pop on a full FIFO
        do_reset(); p0 = pops;
        repeat (9) begin drive(2, 0); step(); end
        idle(); step();
        chk("ovf_drop", drop_cnt, 1);
        chk("ovf_msg3", msg_cnt3, 9);
        chk("ovf_valid", trace_valid, 1);
        drive(0, 0); step();
        idle(); tr_rdy = 1'b1; step();
        chk("fullpp_drop", drop_cnt, 1);
        repeat (7) step();
        chk("fullpp_occ8", trace_valid, 1);
        step();
        chk("fullpp_empty", trace_valid, 0);
        chk("fullpp_pops", pops - p0, 9);

        // reset in the middle of a message
        do_reset();
        drive(0, 3); step();
        drive(0, 1); step();
        idle(); step();
        do_reset();
        chk("midrst_valid", trace_valid, 0);
        chk_counts("midrst");
        tr_rdy = 1'b1; p0 = pops;
        drive(0, 0); step();
        idle(); repeat (3) step();
        chk("midrst_msg1", msg_cnt1, 1);
        chk("midrst_pops", pops - p0, 1);

        // timestamps of two headers five cycles apart
        got_ts.delete();
        drive(1, 0); step();
        idle(); repeat (4) step();
        drive(1, 0); step();
        idle(); repeat (3) step();
        chk("ts_n", got_ts.size(), 2);
        if (got_ts.size() >= 2) chk("ts_delta", 16'(got_ts[1] - got_ts[0]), TS_DELTA);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 3; c++) begin
                val[c] = $urandom_range(0, 1) == 1;
                rdy[c] = $urandom_range(0, 3) != 0;
                dat[c] = {$urandom, $urandom};
                dat[c][29:22] = 8'($urandom_range(0, 3));
            end
            tr_rdy = i < 1500 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0;
            step();
            if (i % 300 == 299) chk_counts("rand");
        end
        idle(); tr_rdy = 1'b1;
        repeat (DEPTH + 4) step();
        chk_counts("drain");
        chk("drain_valid", trace_valid, 0);
        chk("drain_left", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/l2_noc_trace.md
L2_NOC_TRACE -- requirements
Module: l2_noc_trace

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, trace FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter CNT_W, default 16, width of per-channel message counters.
REQ-003 SHALL have clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have noc1_valid_in / noc1_data_in / noc1_ready_in  input  1/`NOC_DATA_WIDTH/1  passive tap of L2 NOC1 input.
REQ-006 SHALL have noc2_valid_out / noc2_data_out / noc2_ready_out  input  1/`NOC_DATA_WIDTH/1  passive tap of L2 NOC2 output.
REQ-007 SHALL have noc3_valid_in / noc3_data_in / noc3_ready_in  input  1/`NOC_DATA_WIDTH/1  passive tap of L2 NOC3 input.
REQ-008 SHALL have trace_valid  output  1  FIFO head entry available.
REQ-009 SHALL have trace_data  output  2+`NOC_DATA_WIDTH+16  {chan_id[1:0], header, timestamp[15:0]}; chan_id 1=noc1, 2=noc2, 3=noc3.
REQ-010 SHALL have trace_ready  input  1  consumer pops head when trace_valid && trace_ready.
REQ-011 SHALL have msg_cnt1 / msg_cnt2 / msg_cnt3  output  CNT_W each  headers seen per channel.
REQ-012 SHALL have drop_cnt  output  CNT_W  headers not captured.

Function
REQ-013 A flit SHALL count only when valid && ready on its channel; tap inputs SHALL never be driven or back-pressured.
REQ-014 Each channel SHALL run a two-state FSM: HDR (next flit is header) and BODY (remaining payload flits).
REQ-015 In HDR, an accepted flit SHALL be a header; its `MSG_LENGTH field loads remaining count; length 0 stays HDR, else goes BODY.
REQ-016 In BODY, each accepted flit SHALL decrement remaining; at 1 -> 0 transition SHALL return to HDR.
REQ-017 Each header SHALL increment its msg_cntN by one, saturating at all-ones.
REQ-018 Headers SHALL be pushed into the trace FIFO in the cycle after acceptance (1-cycle capture latency); at most one push per cycle.
REQ-019 Simultaneous headers SHALL be resolved by fixed priority noc1 > noc3 > noc2; losers SHALL be dropped, each adding 1 to drop_cnt.
REQ-020 Header arriving with FIFO full SHALL be dropped and counted, unless a pop occurs in the same cycle, in which case it is pushed.
REQ-021 Push and pop in the same cycle with FIFO non-empty SHALL leave occupancy unchanged; data order SHALL be strict FIFO.
REQ-022 trace_data SHALL be stable while trace_valid && !trace_ready.
REQ-023 drop_cnt SHALL saturate at all-ones; multiple drops in one cycle SHALL add their count (max 3) with saturation.
REQ-024 Read/write pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL use an extra pointer bit.

Reset
REQ-025 On rst_n low: all FSMs HDR, remaining counts 0, FIFO empty, trace_valid 0, msg_cnt1..3 0, drop_cnt 0, timestamp 0.
REQ-026 Reset mid-message SHALL discard partial state; the first accepted flit after release SHALL be treated as a header.

Configuration
REQ-027 Macro L2_NOC_TRACE_TIMESTAMP_EN defined: free-running 16-bit cycle counter (wraps 0xFFFF->0) recorded into timestamp field at header acceptance.
REQ-028 Macro L2_NOC_TRACE_TIMESTAMP_EN undefined: no counter instantiated; timestamp field SHALL read 0.

Structure
REQ-029 Channel-id encodings, trace entry width, and field offsets SHALL live in the shared define.h header; header field positions SHALL use existing `MSG_LENGTH macros.
REQ-030 FIFO SHALL be a sub-module l2_noc_trace_fifo (parameterised width/depth, push/pop/full/empty); FSMs and counters stay in top.
REQ-031 Block SHALL be instantiable as `L2_DBG_MODULE.

Verification
REQ-032 noc1 header length 2 then 2 payload flits, trace_ready=1 -> one entry chan_id=1, msg_cnt1=1, payload not captured.
REQ-033 noc1, noc2, noc3 headers (length 0) same cycle -> one entry chan_id=1, drop_cnt=2, all msg_cnt=1.
REQ-034 trace_ready=0, 9 length-0 noc3 headers -> 8 entries retained in order, drop_cnt=1, msg_cnt3=9.
REQ-035 FIFO full, header and pop same cycle -> header captured, drop_cnt unchanged, occupancy stays 8.
REQ-036 rst_n pulsed after header length 3 + 1 payload -> next flit captured as header; all counters 0 before it.
REQ-037 Timestamp enabled, headers 5 cycles apart -> timestamp delta 5; disabled -> timestamp 0.
